// File: rtl/snake_pkg.sv
// snake_pkg: direction and debounce-state encodings shared by the direction input path.
// Contents:
//   DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT  2-bit game direction codes
//   DIR_RESET                           direction after reset (RIGHT)
//   db_state_t                          per-button debounce FSM states
//   dir_opposite()                      reverse of a direction (flip bit 0)
package snake_pkg;
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;
    localparam logic [1:0] DIR_RESET = DIR_RIGHT;

    typedef enum logic [1:0] {
        DB_RELEASED,
        DB_ARMING,
        DB_PRESSED,
        DB_RELEASING
    } db_state_t;

    function automatic logic [1:0] dir_opposite(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction
endpackage

// File: rtl/debounce_fsm.sv
// debounce_fsm: synchronises and debounces one raw active-low button.
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   i_raw_n        raw button, active-low, asynchronous to clk
//   o_level        debounced level, active-high (PRESSED or RELEASING)
//   o_press_pulse  one-cycle pulse after the ARMING->PRESSED transition
// DEBOUNCE_CYCLES must be at least 2; 2**CNT_W must exceed DEBOUNCE_CYCLES.
module debounce_fsm
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw_n,
    output logic o_level,
    output logic o_press_pulse
);
    logic [1:0]       r_sync;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sync;
    logic             w_done;

    assign w_sync = r_sync[1];
    // The counter reaches DEBOUNCE_CYCLES-1 on the same edge the state switches,
    // so the decision is taken one count early.
    assign w_done = r_cnt >= CNT_W'(DEBOUNCE_CYCLES - 2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync        <= '0;
            r_state       <= DB_RELEASED;
            r_cnt         <= '0;
            o_level       <= 1'b0;
            o_press_pulse <= 1'b0;
        end else begin
            r_sync        <= {r_sync[0], ~i_raw_n};
            o_press_pulse <= 1'b0;
            r_cnt         <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
            case (r_state)
                DB_RELEASED:
                    if (w_sync) begin
                        r_state <= DB_ARMING;
                        r_cnt   <= '0;
                    end
                DB_ARMING:
                    if (!w_sync) begin
                        r_state <= DB_RELEASED;
                        r_cnt   <= '0;
                    end else if (w_done) begin
                        r_state       <= DB_PRESSED;
                        o_level       <= 1'b1;
                        o_press_pulse <= 1'b1;
                    end
                DB_PRESSED:
                    if (!w_sync) begin
                        r_state <= DB_RELEASING;
                        r_cnt   <= '0;
                    end
                DB_RELEASING:
                    if (w_sync) begin
                        r_state <= DB_PRESSED;
                    end else if (w_done) begin
                        r_state <= DB_RELEASED;
                        o_level <= 1'b0;
                    end
            endcase
        end
    end
endmodule

// File: rtl/dir_input_conditioner.sv
// dir_input_conditioner: turns four bouncing buttons into a committed game direction.
// Ports:
//   clk, reset                       system clock, asynchronous active-low reset
//   up/down/left/right_button        raw buttons, active-low
//   tick                             one-cycle game-step pulse
//   dir                              committed direction (00 UP, 01 DOWN, 10 LEFT, 11 RIGHT)
//   dir_changed                      pulse the cycle after a commit that altered dir
//   btn_state                        debounced levels {up,down,left,right}
// Build option: DIR_REVERSE_BLOCK_EN rejects a candidate that reverses the current dir.
module dir_input_conditioner
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up_button,
    input  logic       down_button,
    input  logic       left_button,
    input  logic       right_button,
    input  logic       tick,
    output logic [1:0] dir,
    output logic       dir_changed,
    output logic [3:0] btn_state
);
    logic [3:0] w_raw_n;
    logic [3:0] w_press;
    logic [1:0] w_ev_dir;
    logic [1:0] w_cand;
    logic       w_ev;
    logic       w_valid;
    logic       w_accept;
    logic [1:0] r_pend_dir;
    logic       r_pend_v;

    assign w_raw_n = {up_button, down_button, left_button, right_button};

    for (genvar b = 0; b < 4; b++) begin : g_btn
        debounce_fsm #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk          (clk),
            .reset        (reset),
            .i_raw_n      (w_raw_n[b]),
            .o_level      (btn_state[b]),
            .o_press_pulse(w_press[b])
        );
    end

    assign w_ev     = |w_press;
    assign w_ev_dir = w_press[3] ? DIR_UP : w_press[2] ? DIR_DOWN : w_press[1] ? DIR_LEFT : DIR_RIGHT;
    assign w_cand   = w_ev ? w_ev_dir : r_pend_dir;
    assign w_valid  = w_ev | r_pend_v;
`ifdef DIR_REVERSE_BLOCK_EN
    assign w_accept = w_valid && (w_cand != dir_opposite(dir));
`else
    assign w_accept = w_valid;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir         <= DIR_RESET;
            dir_changed <= 1'b0;
            r_pend_dir  <= DIR_RESET;
            r_pend_v    <= 1'b0;
        end else begin
            dir_changed <= tick && w_accept && (w_cand != dir);
            if (tick) begin
                r_pend_v <= 1'b0;
                if (w_accept) dir <= w_cand;
            end else if (w_ev) begin
                r_pend_dir <= w_ev_dir;
                r_pend_v   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dir_input_conditioner.sv
// tb_dir_input_conditioner: directed vector table, reset corner case and random run against a reference model.
module tb_dir_input_conditioner;
    localparam int D = 4;
`ifdef DIR_REVERSE_BLOCK_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] raw = 4'hF;
    logic       tick = 1'b0;
    logic [1:0] dir;
    logic       dir_changed;
    logic [3:0] btn_state;

    int checks = 0;
    int failures = 0;

    dir_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .up_button   (raw[3]),
        .down_button (raw[2]),
        .left_button (raw[1]),
        .right_button(raw[0]),
        .tick        (tick),
        .dir         (dir),
        .dir_changed (dir_changed),
        .btn_state   (btn_state)
    );

    always #5 clk = ~clk;

    // Reference model: a button's debounced level flips once the synchronised
    // input has disagreed with it for D consecutive samples.
    logic [1:0] m_dir, n_dir, m_pend, n_pend, ed, cand;
    logic       m_chg, n_chg, m_pv, n_pv, ev, acc;
    logic [3:0] m_lvl, n_lvl, m_pulse, n_pulse, m_s1, m_s2;
    int         m_run [4];
    int         n_run [4];

    always_comb begin
        n_dir   = m_dir;
        n_chg   = 1'b0;
        n_pend  = m_pend;
        n_pv    = m_pv;
        n_lvl   = m_lvl;
        n_pulse = '0;
        n_run   = m_run;
        ev      = |m_pulse;
        ed      = m_pulse[3] ? 2'd0 : m_pulse[2] ? 2'd1 : m_pulse[1] ? 2'd2 : 2'd3;
        cand    = ev ? ed : m_pend;
        acc     = (ev || m_pv) && !(BLK && cand == (m_dir ^ 2'b01));
        if (tick) begin
            n_pv = 1'b0;
            if (acc) begin
                n_dir = cand;
                n_chg = cand != m_dir;
            end
        end else if (ev) begin
            n_pend = ed;
            n_pv   = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            n_run[i] = (m_s2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
            if (n_run[i] == D) begin
                n_lvl[i]   = ~m_lvl[i];
                n_pulse[i] = ~m_lvl[i];
                n_run[i]   = 0;
            end
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_dir <= 2'd3; m_chg <= 1'b0; m_pend <= 2'd3; m_pv <= 1'b0;
            m_lvl <= '0; m_pulse <= '0; m_s1 <= '0; m_s2 <= '0;
            m_run <= '{default: 0};
        end else begin
            m_dir <= n_dir; m_chg <= n_chg; m_pend <= n_pend; m_pv <= n_pv;
            m_lvl <= n_lvl; m_pulse <= n_pulse; m_run <= n_run;
            m_s2 <= m_s1; m_s1 <= ~raw;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_dir", {6'd0, dir}, {6'd0, m_dir});
        check("model_chg", {7'd0, dir_changed}, {7'd0, m_chg});
        check("model_btn", {4'd0, btn_state}, {4'd0, m_lvl});
    end

    typedef struct {
        logic [3:0] raw;
        logic       tk;
        int         n;
        logic [1:0] d;
        logic       chg;
        logic [3:0] btn;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] r, logic t, int n, logic [1:0] d, logic c, logic [3:0] b);
        vec_t v;
        v.raw = r; v.tk = t; v.n = n; v.d = d; v.chg = c; v.btn = b;
        return v;
    endfunction

    task automatic expect_out(input string tag, input logic [1:0] d, input logic c, input logic [3:0] b);
        check({tag, "_dir"}, {6'd0, dir}, {6'd0, d});
        check({tag, "_chg"}, {7'd0, dir_changed}, {7'd0, c});
        check({tag, "_btn"}, {4'd0, btn_state}, {4'd0, b});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] d1;
        d1 = BLK ? 2'd3 : 2'd2;
        tbl.push_back(mk(4'hF, 0, 10, 3, 0, 4'h0));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(4'h7, 0, 3, 3, 0, 4'h0));
            tbl.push_back(mk(4'hF, 0, 3, 3, 0, 4'h0));
        end
        tbl.push_back(mk(4'hF, 1, 1, 3, 0, 4'h0));
        tbl.push_back(mk(4'h7, 0, 5, 3, 0, 4'h0));
        tbl.push_back(mk(4'h7, 0, 1, 3, 0, 4'h8));
        tbl.push_back(mk(4'h7, 1, 1, 0, 1, 4'h8));
        tbl.push_back(mk(4'h7, 0, 1, 0, 0, 4'h8));
        tbl.push_back(mk(4'hF, 0, 8, 0, 0, 4'h0));
        tbl.push_back(mk(4'hE, 0, 7, 0, 0, 4'h1));
        tbl.push_back(mk(4'hE, 1, 1, 3, 1, 4'h1));
        tbl.push_back(mk(4'hF, 0, 8, 3, 0, 4'h0));
        tbl.push_back(mk(4'hD, 0, 7, 3, 0, 4'h2));
        tbl.push_back(mk(4'hD, 1, 1, d1, !BLK, 4'h2));
        tbl.push_back(mk(4'hF, 0, 8, d1, 0, 4'h0));
        tbl.push_back(mk(4'hF, 1, 1, d1, 0, 4'h0));
        tbl.push_back(mk(4'hE, 0, 7, d1, 0, 4'h1));
        tbl.push_back(mk(4'hE, 1, 1, 3, !BLK, 4'h1));
        tbl.push_back(mk(4'hF, 0, 8, 3, 0, 4'h0));
        tbl.push_back(mk(4'h7, 0, 7, 3, 0, 4'h8));
        tbl.push_back(mk(4'hF, 0, 8, 3, 0, 4'h0));
        tbl.push_back(mk(4'hB, 0, 7, 3, 0, 4'h4));
        tbl.push_back(mk(4'hF, 0, 8, 3, 0, 4'h0));
        tbl.push_back(mk(4'hF, 1, 1, 1, 1, 4'h0));
        tbl.push_back(mk(4'hF, 1, 1, 1, 0, 4'h0));
        tbl.push_back(mk(4'hD, 0, 7, 1, 0, 4'h2));
        tbl.push_back(mk(4'hF, 0, 8, 1, 0, 4'h0));
        tbl.push_back(mk(4'hF, 1, 1, 2, 1, 4'h0));
        tbl.push_back(mk(4'h3, 0, 7, 2, 0, 4'hC));
        tbl.push_back(mk(4'hF, 0, 8, 2, 0, 4'h0));
        tbl.push_back(mk(4'hF, 1, 1, 0, 1, 4'h0));
        tbl.push_back(mk(4'hD, 0, 6, 0, 0, 4'h2));
        tbl.push_back(mk(4'hD, 1, 1, 2, 1, 4'h2));
        tbl.push_back(mk(4'hF, 0, 8, 2, 0, 4'h0));
        tbl.push_back(mk(4'hF, 1, 1, 2, 0, 4'h0));

        repeat (3) @(negedge clk);
        expect_out("reset", 2'd3, 1'b0, 4'h0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            raw  = tbl[i].raw;
            tick = tbl[i].tk;
            repeat (tbl[i].n) @(negedge clk);
            expect_out($sformatf("vec%0d", i), tbl[i].d, tbl[i].chg, tbl[i].btn);
        end
        tick = 1'b0;

        raw = 4'h7;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        expect_out("midrst_in", 2'd3, 1'b0, 4'h0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        expect_out("midrst_5", 2'd3, 1'b0, 4'h0);
        @(negedge clk);
        expect_out("midrst_6", 2'd3, 1'b0, 4'h8);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        expect_out("midrst_tick1", 2'd0, 1'b1, 4'h8);
        @(negedge clk);
        expect_out("midrst_tick2", 2'd0, 1'b0, 4'h8);
        tick = 1'b0;
        @(negedge clk);
        expect_out("midrst_hold", 2'd0, 1'b0, 4'h8);
        raw = 4'hF;
        repeat (8) @(negedge clk);

        for (int s = 0; s < 250; s++) begin
            raw = 4'($urandom);
            for (int c = $urandom_range(1, 12); c > 0; c--) begin
                tick = ($urandom_range(0, 5) == 0);
                @(negedge clk);
            end
        end
        tick = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
